// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII W/R command parser bridging UART FIFOs to a register bus
module uart_cmd_parser #(
  parameter logic [7:0] ACK_CHAR     = 8'h4B,
  parameter logic [7:0] ERR_CHAR     = 8'h3F,
  parameter int         ERR_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_empty,
  input  logic [7:0]              r_data,
  output logic                    rd_uart,
  input  logic                    tx_empty,
  output logic                    wr_uart,
  output logic [7:0]              w_data,
  output logic [7:0]              reg_addr,
  output logic [7:0]              reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [7:0]              reg_rdata,
  output logic                    busy,
  output logic [ERR_CNT_BITS-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_CMD, S_ARG, S_TERM, S_FLUSH, S_EXEC, S_RDWAIT, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        is_write_q;
  logic [15:0] shift_q;
  logic [31:0] resp_q;
  logic [2:0]  resp_cnt_q;
  logic        wr_gap_q;

  logic take, tx_ok, is_term, is_hex_b;
  logic pop, push, start_w, start_r, shift_en, go_exec, load_ack, load_rd, load_err;

  function automatic logic hex_ok(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // rd_uart/wr_uart are registered, so a high strobe marks a FIFO flag that is still stale
  assign take     = !rx_empty && !rd_uart;
  assign tx_ok    = tx_empty && !wr_uart && !wr_gap_q;
  assign is_term  = (r_data == 8'h0D) || (r_data == 8'h0A);
  assign is_hex_b = hex_ok(r_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    push     = 1'b0;
    start_w  = 1'b0;
    start_r  = 1'b0;
    shift_en = 1'b0;
    go_exec  = 1'b0;
    load_ack = 1'b0;
    load_rd  = 1'b0;
    load_err = 1'b0;
    reg_we   = 1'b0;
    reg_re   = 1'b0;
    case (state_q)
      S_CMD: if (take) begin
        pop = 1'b1;
        if (r_data == 8'h57) begin
          start_w = 1'b1;
          state_d = S_ARG;
        end else if (r_data == 8'h52) begin
          start_r = 1'b1;
          state_d = S_ARG;
        end else if (!is_term) begin
          state_d = S_FLUSH;
        end
      end
      S_ARG: if (take) begin
        pop = 1'b1;
        if (is_hex_b) begin
          shift_en = 1'b1;
          if (cnt_q == 3'd1) state_d = S_TERM;
        end else if (is_term) begin
          load_err = 1'b1;
          state_d  = S_RESP;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_TERM: if (take) begin
        pop = 1'b1;
        if (is_term) begin
          go_exec = 1'b1;
          state_d = S_EXEC;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: if (take) begin
        pop = 1'b1;
        if (is_term) begin
          load_err = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_EXEC: begin
        if (is_write_q) begin
          reg_we   = 1'b1;
          load_ack = 1'b1;
          state_d  = S_RESP;
        end else begin
          reg_re  = 1'b1;
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        load_rd = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_cnt_q == 3'd0) begin
          state_d = S_CMD;
        end else if (tx_ok) begin
          push = 1'b1;
          if (resp_cnt_q == 3'd1) state_d = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= 3'd0;
      is_write_q <= 1'b0;
      shift_q    <= 16'h0000;
      resp_q     <= 32'h0;
      resp_cnt_q <= 3'd0;
      wr_gap_q   <= 1'b0;
      rd_uart    <= 1'b0;
      wr_uart    <= 1'b0;
      w_data     <= 8'h00;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      rd_uart  <= pop;
      wr_uart  <= push;
      wr_gap_q <= wr_uart;
      busy     <= (state_d != S_CMD) || push;
      if (start_w) begin
        is_write_q <= 1'b1;
        cnt_q      <= 3'd4;
      end else if (start_r) begin
        is_write_q <= 1'b0;
        cnt_q      <= 3'd2;
      end else if (shift_en) begin
        shift_q <= {shift_q[11:0], hex_val(r_data)};
        cnt_q   <= cnt_q - 3'd1;
      end
      // Reads shift only two nibbles, so the address always lands in the low byte
      if (go_exec) begin
        reg_addr <= is_write_q ? shift_q[15:8] : shift_q[7:0];
        if (is_write_q) reg_wdata <= shift_q[7:0];
      end
      if (load_ack) begin
        resp_q     <= {ACK_CHAR, 8'h0D, 8'h0A, 8'h00};
        resp_cnt_q <= 3'd3;
      end else if (load_rd) begin
        resp_q     <= {hex_char(reg_rdata[7:4]), hex_char(reg_rdata[3:0]), 8'h0D, 8'h0A};
        resp_cnt_q <= 3'd4;
      end else if (load_err) begin
        resp_q     <= {ERR_CHAR, 8'h0D, 8'h0A, 8'h00};
        resp_cnt_q <= 3'd3;
      end else if (push) begin
        w_data     <= resp_q[31:24];
        resp_q     <= {resp_q[23:0], 8'h00};
        resp_cnt_q <= resp_cnt_q - 3'd1;
      end
      if (load_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser with RX/TX FIFO models
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_empty = 1'b1;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_parser dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_empty(tx_empty), .wr_uart(wr_uart), .w_data(w_data), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0]  rx_q[$];
  logic [7:0]  obs_tx[$], exp_tx[$];
  logic [16:0] obs_reg[$], exp_reg[$];
  int  pass_cnt = 0, total_cnt = 0;
  int  viol = 0, tx_drain = 0, exp_err = 0;
  logic tx_hold = 1'b0, rd_prev = 1'b0;
  string got, want;

  // FIFO models and bus monitor, updated mid-cycle away from the DUT's sampling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rd_uart) begin
        if (rd_prev) viol++;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
      end
      rd_prev = rd_uart;
      if (reg_we && reg_re) viol++;
      if (reg_we) obs_reg.push_back({1'b1, reg_addr, reg_wdata});
      if (reg_re) obs_reg.push_back({1'b0, reg_addr, 8'h00});
      if (wr_uart) begin
        if (!tx_empty) viol++;
        obs_tx.push_back(w_data);
        tx_drain = 2;
      end else if (tx_drain > 0) begin
        tx_drain--;
      end
      tx_empty = (tx_drain == 0) && !tx_hold;
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  function automatic string fmt_b(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic string fmt_r(input logic [16:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%s:%02h:%02h ", q[i][16] ? "W" : "R", q[i][15:8], q[i][7:0])};
    return s;
  endfunction

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
  endtask

  task automatic exp_bad();
    exp_str("?\r\n");
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk); #1;
      n++;
      if (rx_q.size() == 0 && !busy && !rd_uart && !wr_uart && tx_empty) quiet++;
      else quiet = 0;
    end
    total_cnt++;
    if (quiet < 4) $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({rd_uart, wr_uart, w_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err_cnt} !== '0)
      $display("FAIL reset_outputs: got rd=%b wr=%b wd=%h a=%h d=%h we=%b re=%b busy=%b err=%0d, required all 0",
               rd_uart, wr_uart, w_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err_cnt);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    wait_idle(50, "reset");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send("W12");
    while (rx_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || reg_we !== 1'b0 || rd_uart !== 1'b0)
      $display("FAIL reset_mid_state: got busy=%b we=%b rd=%b, required 0 0 0", busy, reg_we, rd_uart);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    reg_rdata = 8'h5C;
    exp_reg.push_back({1'b0, 8'h34, 8'h00});
    exp_str("5C\r\n");
    send("R34\r");
    wait_idle(500, "reset_mid");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL reset_mid_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL reset_mid_tx: got '%s' required '%s'", got, want); else pass_cnt++;
  endtask

  task automatic test_write();
    exp_reg.push_back({1'b1, 8'h3F, 8'hA5});
    exp_str("K\r\n");
    send("W3Fa5\r");
    wait_idle(500, "write");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL write_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL write_tx: got '%s' required '%s'", got, want); else pass_cnt++;
    total_cnt++;
    if (reg_addr !== 8'h3F || reg_wdata !== 8'hA5 || err_cnt !== 8'd0)
      $display("FAIL write_hold: got a=%h d=%h err=%0d, required 3f a5 0", reg_addr, reg_wdata, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_read();
    reg_rdata = 8'hA5;
    exp_reg.push_back({1'b0, 8'h3F, 8'h00});
    exp_str("A5\r\n");
    send("R3F\r\n");
    wait_idle(500, "read");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL read_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL read_tx: got '%s' required '%s'", got, want); else pass_cnt++;
  endtask

  task automatic test_errors();
    exp_bad();
    exp_bad();
    send("X12\rW1G00\r");
    wait_idle(800, "errors");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL errors_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL errors_tx: got '%s' required '%s'", got, want); else pass_cnt++;
    total_cnt++;
    if (err_cnt !== 8'(exp_err)) $display("FAIL errors_cnt: got %0d required %0d", err_cnt, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_short_arg();
    reg_rdata = 8'h3C;
    exp_bad();
    exp_reg.push_back({1'b0, 8'h01, 8'h00});
    exp_str("3C\r\n");
    send("R1\rR01\r");
    wait_idle(800, "short");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL short_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL short_tx: got '%s' required '%s'", got, want); else pass_cnt++;
    total_cnt++;
    if (err_cnt !== 8'(exp_err)) $display("FAIL short_cnt: got %0d required %0d", err_cnt, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_tx_stall();
    int wr_seen = 0;
    tx_hold = 1'b1;
    reg_rdata = 8'h0B;
    repeat (2) @(negedge clk);
    exp_reg.push_back({1'b0, 8'h7E, 8'h00});
    exp_str("0B\r\n");
    send("R7e\r");
    repeat (50) begin
      @(negedge clk); #1;
      if (wr_uart) wr_seen++;
    end
    total_cnt++;
    if (wr_seen != 0 || obs_tx.size() != 0 || busy !== 1'b1)
      $display("FAIL stall_hold: got wr_pulses=%0d tx_bytes=%0d busy=%b, required 0 0 1", wr_seen, obs_tx.size(), busy);
    else pass_cnt++;
    tx_hold = 1'b0;
    wait_idle(500, "stall");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL stall_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL stall_tx: got '%s' required '%s'", got, want); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    reg_rdata = 8'h9F;
    exp_reg.push_back({1'b1, 8'h01, 8'h02});
    exp_reg.push_back({1'b0, 8'h02, 8'h00});
    exp_reg.push_back({1'b1, 8'h03, 8'h04});
    exp_str("K\r\n9F\r\nK\r\n");
    send("W0102\rR02\r\nW0304\n");
    wait_idle(1500, "b2b");
    got = fmt_r(obs_reg); want = fmt_r(exp_reg); obs_reg.delete(); exp_reg.delete();
    total_cnt++;
    if (got != want) $display("FAIL b2b_regs: got '%s' required '%s'", got, want); else pass_cnt++;
    got = fmt_b(obs_tx); want = fmt_b(exp_tx); obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (got != want) $display("FAIL b2b_tx: got '%s' required '%s'", got, want); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int bad = 0;
    int need = 255 - exp_err;
    for (int i = 0; i < need; i++) begin send("Z\r"); exp_bad(); end
    wait_idle(30000, "sat_fill");
    total_cnt++;
    if (err_cnt !== 8'd255) $display("FAIL sat_reach: got %0d required 255", err_cnt); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin send("Z\r"); exp_bad(); end
    wait_idle(1000, "sat_hold");
    total_cnt++;
    if (err_cnt !== 8'd255) $display("FAIL sat_hold: got %0d required 255", err_cnt); else pass_cnt++;
    total_cnt++;
    if (obs_tx.size() != exp_tx.size()) begin
      $display("FAIL sat_tx_len: got %0d bytes required %0d", obs_tx.size(), exp_tx.size());
    end else begin
      foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i]) bad++;
      if (bad != 0) $display("FAIL sat_tx: got %0d differing bytes required 0", bad);
      else pass_cnt++;
    end
    obs_tx.delete(); exp_tx.delete();
    total_cnt++;
    if (obs_reg.size() != 0) $display("FAIL sat_regs: got %0d strobes required 0", obs_reg.size());
    else pass_cnt++;
    obs_reg.delete();
  endtask

  task automatic test_protocol();
    total_cnt++;
    if (viol != 0) $display("FAIL protocol: got %0d handshake violations required 0", viol);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write();
    test_read();
    test_errors();
    test_short_arg();
    test_tx_stall();
    test_back_to_back();
    test_saturation();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
ASCII register-access command parser that sits directly downstream of the UART block. It consumes bytes from the UART RX FIFO and decodes "W"/"R" commands into single-cycle register-bus transactions. It returns ASCII responses through the UART TX FIFO. This block gives the host a serial control path to the firmware's configuration registers.

Parameters:
ACK_CHAR, 8'h4B ("K"), first byte of a successful-write response
ERR_CHAR, 8'h3F ("?"), first byte of an error response
ERR_CNT_BITS, 8, width of the saturating error counter

Ports:
clk  input  1  system clock (same domain as the UART)
reset  input  1  asynchronous, active-high reset
rx_empty  input  1  UART RX FIFO empty flag
r_data  input  8  UART RX FIFO head byte; valid while rx_empty=0
rd_uart  output  1  one-cycle pop strobe to the RX FIFO
tx_empty  input  1  UART TX FIFO empty flag
wr_uart  output  1  one-cycle push strobe to the TX FIFO
w_data  output  8  byte pushed while wr_uart=1
reg_addr  output  8  register address
reg_wdata  output  8  register write data
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  8  read data; valid the cycle after reg_re
busy  output  1  high from the first accepted command byte until the last response byte is pushed
err_cnt  output  ERR_CNT_BITS  count of rejected commands, saturating

Behaviour:
- Reset: asynchronous, active-high. Returns to S_CMD. All outputs drive 0. Clears the digit counter and the response buffer. Reset mid-command or mid-response drops the command; nothing further is pushed.
- Grammar:
  - Write: 'W' followed by 4 hex digits (AA DD), then a terminator.
  - Read: 'R' followed by 2 hex digits (AA), then a terminator.
  - Terminator: CR (0x0D) or LF (0x0A).
  - Hex digits 0-9, A-F and a-f are accepted. Command letters are uppercase only.
- RX handshake:
  - A byte is consumed when rx_empty=0: the byte is sampled from r_data and rd_uart is pulsed for 1 cycle.
  - rd_uart is never high in two consecutive cycles (1-cycle gap so the FIFO flag can settle).
  - No pops occur in S_EXEC, S_RESP or S_RDWAIT.
- States:
  - S_CMD:
    - 'W' or 'R' -> S_ARG with the digit count set to 4 or 2.
    - CR or LF -> ignored, stay in S_CMD, no response (this absorbs CRLF pairs).
    - Any other byte -> S_FLUSH.
  - S_ARG:
    - Each hex digit shifts its nibble into a 16-bit shift register, MSB first, and decrements the count.
    - Count reaches 0 -> S_TERM.
    - Non-hex byte -> S_FLUSH.
    - Terminator received early -> error response immediately (no flush).
  - S_TERM:
    - CR or LF -> S_EXEC.
    - Any other byte -> S_FLUSH.
  - S_FLUSH: discards bytes up to and including the next CR or LF, then loads the error response.
  - S_EXEC (1 cycle):
    - Write: drive reg_addr=AA, reg_wdata=DD, pulse reg_we; load "K\r\n".
    - Read: drive reg_addr=AA, pulse reg_re -> S_RDWAIT.
  - S_RDWAIT (1 cycle): sample reg_rdata; load two uppercase hex digits + "\r\n" -> S_RESP.
  - S_RESP: sends the loaded buffer (3 or 4 bytes) -> S_CMD.
- Error handling: an error loads ERR_CHAR "\r\n" and increments err_cnt. At all-ones err_cnt holds.
- TX handshake:
  - A byte is pushed only when tx_empty=1: wr_uart=1 for 1 cycle with w_data valid in the same cycle.
  - After each push, wait at least 1 cycle before sampling tx_empty again.
  - At most one byte is ever outstanding in the TX FIFO, so it can never overflow.
- reg_addr and reg_wdata hold their last values between transactions.
- reg_we and reg_re are never high together.
- Bytes arriving during S_RESP wait in the RX FIFO. The parser does not drop them; loss can only come from RX FIFO overflow upstream.

Test Plan:
- Reset mid-stream: "W12" then assert reset, then "R34\r" -> no reg_we pulses; the read reg_re is issued cleanly with reg_addr=0x34.
- "W3Fa5\r" -> exactly one reg_we pulse with reg_addr=0x3F, reg_wdata=0xA5; TX bytes 0x4B 0x0D 0x0A; err_cnt=0.
- "R3F\r\n" with reg_rdata=0xA5 -> one reg_re pulse with reg_addr=0x3F; TX "A5\r\n"; the trailing LF produces no extra output.
- "X12\r" then "W1G00\r" -> no register strobes; TX "?\r\n" twice; err_cnt=2.
- "R1\r" -> error after 1 digit; TX "?\r\n"; the next "R01\r" is accepted normally.
- Hold tx_empty=0 for 50 cycles during a read response -> wr_uart stays low; the full response completes after release.
- Saturation: 256 bad commands with ERR_CNT_BITS=8 -> err_cnt stops at 255.
